// File: rtl/clock_divider_if.sv
// Controller-side bundle for the SPI serial-clock generator:
// configuration and start in, ready and divided clock out.
interface clock_divider_if;
    logic [8:0] i_config;
    logic       i_start_n;
    logic       o_ready;
    logic       o_clk;

    modport master (
        output i_config,
        output i_start_n,
        input  o_ready,
        input  o_clk
    );

    modport slave (
        input  i_config,
        input  i_start_n,
        output o_ready,
        output o_clk
    );
endinterface

// File: rtl/clock_divider.sv
// Programmable SCLK generator: on start, emits exactly 8 periods of i_clk/D on o_clk,
// low-first within each period, then returns to idle with o_clk low.
module clock_divider (
    input  logic            i_clk,
    input  logic            i_rst,
    clock_divider_if.slave  bus
);

    localparam int unsigned DIV_W   = 8;
    localparam int unsigned PER_W   = 3;
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(4);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(7);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q,  state_d;
    logic [DIV_W-1:0]   div_q,    div_d;
    logic [DIV_W-1:0]   phase_q,  phase_d;
    logic [PER_W-1:0]   period_q, period_d;
    logic               ready_q,  ready_d;
    logic               sclk_q,   sclk_d;

    logic [DIV_W-1:0]   cfg_div;
    logic               cfg_load;
    logic [DIV_W-1:0]   half;
    logic               phase_last;

    assign cfg_div    = bus.i_config[8:1];
    assign cfg_load   = bus.i_config[0];
    assign half       = div_q >> 1;
    assign phase_last = (phase_q == (div_q - DIV_W'(1)));

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            div_q    <= DIV_RST;
            phase_q  <= '0;
            period_q <= '0;
            ready_q  <= 1'b1;
            sclk_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            phase_q  <= phase_d;
            period_q <= period_d;
            ready_q  <= ready_d;
            sclk_q   <= sclk_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        phase_d  = phase_q;
        period_d = period_q;
        ready_d  = ready_q;
        sclk_d   = sclk_q;

        unique case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                sclk_d  = 1'b0;
                // Divisors below 2 cannot form a low and a high phase; clamp them.
                if (cfg_load) begin
                    div_d = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
                end
                if (!bus.i_start_n) begin
                    state_d  = ST_RUN;
                    ready_d  = 1'b0;
                    phase_d  = '0;
                    period_d = '0;
                end
            end

            ST_RUN: begin
                if (phase_last) begin
                    phase_d  = '0;
                    period_d = period_q + PER_W'(1);
                end else begin
                    phase_d  = phase_q + DIV_W'(1);
                end
                // o_clk is registered from the upcoming phase so it lines up with phase_q.
                sclk_d = (phase_d >= half);
                if (phase_last && (period_q == PER_LAST)) begin
                    state_d  = ST_IDLE;
                    ready_d  = 1'b1;
                    sclk_d   = 1'b0;
                    period_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.o_ready = ready_q;
    assign bus.o_clk   = sclk_q;

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider with a transfer-level reference model checked every cycle.
module tb_clock_divider;

    logic clk;
    logic rst;

    clock_divider_if bus();

    clock_divider dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a transfer is 8*D cycles; within it, cycle k drives high iff (k mod D) >= D/2.
    int   m_d;
    int   m_k;
    bit   m_busy;
    logic exp_ready;
    logic exp_clk;
    bit   chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_k    = 0;
            m_d    = 4;
        end else if (!m_busy) begin
            if (bus.i_config[0]) begin
                m_d = int'(bus.i_config[8:1]);
                if (m_d < 2) m_d = 2;
            end
            if (!bus.i_start_n) begin
                m_busy = 1'b1;
                m_k    = 0;
            end
        end else begin
            m_k = m_k + 1;
            if (m_k == 8 * m_d) m_busy = 1'b0;
        end
        exp_ready = !m_busy;
        exp_clk   = m_busy && ((m_k % m_d) >= (m_d / 2));
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (bus.o_ready !== exp_ready || bus.o_clk !== exp_clk) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL model t=%0t got ready=%b clk=%b expected ready=%b clk=%b",
                             $time, bus.o_ready, bus.o_clk, exp_ready, exp_clk);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one start (optionally with a divisor load) and measure the transfer.
    task automatic run_xfer(input string name, input bit load, input logic [7:0] div,
                            input bit poke, input int e_busy, input int e_lo, input int e_hi);
        int   busy, lo, hi, rises, n;
        logic prev;
        busy = 0; lo = 0; hi = 0; rises = 0; n = 0; prev = 1'b0;
        @(negedge clk);
        bus.i_config  = {div, load};
        bus.i_start_n = 1'b0;
        @(negedge clk);
        bus.i_config  = '0;
        while (bus.o_ready === 1'b0 && n < 5000) begin
            busy++;
            if (bus.o_clk === 1'b1) hi++; else lo++;
            if (bus.o_clk === 1'b1 && prev === 1'b0) rises++;
            prev = bus.o_clk;
            if (busy == 2) bus.i_start_n = 1'b1;
            if (poke && busy == 10) begin
                bus.i_config  = {8'd2, 1'b1};
                bus.i_start_n = 1'b0;
            end
            if (poke && busy == 11) begin
                bus.i_config  = '0;
                bus.i_start_n = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        bus.i_start_n = 1'b1;
        check({name, "_busy"},  busy,  e_busy);
        check({name, "_low"},   lo,    e_lo);
        check({name, "_high"},  hi,    e_hi);
        check({name, "_rises"}, rises, 8);
        check({name, "_end_ready"}, int'(bus.o_ready), 1);
        check({name, "_end_clk"},   int'(bus.o_clk),   0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int b1, gap, b2, n;
        rst           = 1'b1;
        bus.i_config  = '0;
        bus.i_start_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (15) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", int'(bus.o_ready), 1);
        check("rst_clk",   int'(bus.o_clk),   0);

        run_xfer("d4_default", 1'b0, 8'd0,   1'b0, 32,   16,   16);
        run_xfer("d250",       1'b1, 8'd250, 1'b0, 2000, 1000, 1000);
        run_xfer("d100",       1'b1, 8'd100, 1'b0, 800,  400,  400);
        run_xfer("d4",         1'b1, 8'd4,   1'b0, 32,   16,   16);
        run_xfer("d2",         1'b1, 8'd2,   1'b0, 16,   8,    8);
        run_xfer("d0",         1'b1, 8'd0,   1'b0, 16,   8,    8);
        run_xfer("d1",         1'b1, 8'd1,   1'b0, 16,   8,    8);
        run_xfer("d3",         1'b1, 8'd3,   1'b0, 24,   8,    16);
        run_xfer("poke",       1'b1, 8'd100, 1'b1, 800,  400,  400);
        run_xfer("after_poke", 1'b0, 8'd0,   1'b0, 800,  400,  400);

        // Reset in the middle of a long transfer
        @(negedge clk);
        bus.i_config  = {8'd100, 1'b1};
        bus.i_start_n = 1'b0;
        @(negedge clk);
        bus.i_config  = '0;
        @(negedge clk);
        bus.i_start_n = 1'b1;
        repeat (50) @(negedge clk);
        check("midrst_busy", int'(bus.o_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", int'(bus.o_ready), 1);
        check("midrst_clk",   int'(bus.o_clk),   0);
        rst = 1'b0;
        run_xfer("after_rst", 1'b0, 8'd0, 1'b0, 32, 16, 16);

        // Start held low: back-to-back transfers with a single idle cycle
        @(negedge clk);
        bus.i_config  = {8'd2, 1'b1};
        bus.i_start_n = 1'b0;
        @(negedge clk);
        bus.i_config  = '0;
        b1 = 0; gap = 0; b2 = 0; n = 0;
        while (bus.o_ready === 1'b0 && n < 100) begin b1++; n++; @(negedge clk); end
        while (bus.o_ready === 1'b1 && n < 100) begin gap++; n++; @(negedge clk); end
        bus.i_start_n = 1'b1;
        while (bus.o_ready === 1'b0 && n < 100) begin b2++; n++; @(negedge clk); end
        check("b2b_first", b1,  16);
        check("b2b_gap",   gap, 1);
        check("b2b_second", b2, 16);

        repeat (3) @(negedge clk);
        check("final_ready", int'(bus.o_ready), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
